hamming_rx_deserializer: RTL and testbench

- Upstream feeder for the Hamming decoder stage. Receives Hamming-coded words as a framed serial bitstream.
- Assembles each word into an (IP_BIT+4)-bit parallel codeword laid out exactly as the decoder's IN_code expects.
- Buffers completed codewords in a small FIFO and presents them through a valid/ready handshake.
- No error correction is done here. The output is the raw, uncorrected codeword.

---
 rtl/hamming_rx_deserializer_pkg.sv | 38 +++
 rtl/hamming_cw_fifo.sv | 57 +++++
 rtl/hamming_rx_deserializer.sv | 129 ++++++++++++
 tb/tb_hamming_rx_deserializer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_rx_deserializer_pkg.sv
// Shared definitions for the Hamming serial receive path: FSM states,
// parameter limits and width helpers used by the deserializer and its FIFO.
package hamming_rx_deserializer_pkg;

    // Legal parameter ranges for the receive path.
    localparam int IP_BIT_MIN = 5;
    localparam int IP_BIT_MAX = 11;
    localparam int DEPTH_MIN  = 2;
    localparam int DEPTH_MAX  = 8;

    // Codeword width for the default configuration (IP_BIT = 8).
    localparam int DEFAULT_IP_BIT = 8;
    localparam int DEFAULT_CW     = DEFAULT_IP_BIT + 4;

    // Word-assembly FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Codeword width for a given number of data bits (data + 4 check bits).
    function automatic int cw_width(input int ip_bit);
        return ip_bit + 4;
    endfunction

    // Ceiling log2, used for pointer and counter widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hamming_cw_fifo.sv
// Small synchronous FIFO holding completed codewords. Head is read straight
// from the storage array, so a pushed word is visible one cycle after the
// push edge. Full/empty use pointers one bit wider than the address.
module hamming_cw_fifo
    import hamming_rx_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CW,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              do_pop;
    logic              do_push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop on an empty FIFO is ignored; a push while full only lands if a
    // pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = mem[rd_ptr[AW-1:0]];

    // Pointer and storage update; storage is cleared so head is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/hamming_rx_deserializer.sv
// Serial-to-parallel front end for the Hamming decoder. Collects a framed
// bitstream into CW-bit codewords (first bit at the MSB), queues them and
// hands them out uncorrected. Words that arrive while the queue is full
// and not draining are dropped and counted.
//
// Output handshake: out_valid/out_code describe the queue head; a word is
// transferred on every rising edge where out_valid && out_ready. While
// out_valid=1 and out_ready=0, out_valid and out_code hold steady.
module hamming_rx_deserializer
    import hamming_rx_deserializer_pkg::*;
#(
    parameter int IP_BIT = DEFAULT_IP_BIT,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_start,
    input  logic                    in_bit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IP_BIT+3:0]       out_code,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int CW       = cw_width(IP_BIT);
    localparam int CNT_BITS = clog2(CW + 1);
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CW - 1);
    localparam logic [CNT_BITS-1:0] ONE_CNT  = CNT_BITS'(1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [CNT_BITS-1:0]   cnt_d;
    logic [CW-1:0]         shift_q;
    logic [CW-1:0]         shift_d;
    logic [CW-1:0]         word;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_word;

    // Word-assembly state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: start/restart on in_start, shift on plain valid
    // bits, push the assembled word when its last bit is sampled.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        push    = 1'b0;
        word    = {shift_q[CW-2:0], in_bit};
        case (state_q)
            IDLE: begin
                if (in_valid && in_start) begin
                    shift_d = {{(CW-1){1'b0}}, in_bit};
                    cnt_d   = ONE_CNT;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (in_valid) begin
                    if (in_start) begin
                        // A fresh start abandons the partial word without a flag.
                        shift_d = {{(CW-1){1'b0}}, in_bit};
                        cnt_d   = ONE_CNT;
                    end else if (cnt_q == LAST_CNT) begin
                        push    = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d = word;
                        cnt_d   = cnt_q + ONE_CNT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    hamming_cw_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (out_ready),
        .din   (word),
        .head  (out_code),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;

    // When full the FIFO is non-empty, so a same-cycle out_ready always frees a slot.
    assign drop_word = push && fifo_full && !out_ready;

    // Sticky overflow flag and saturating count of dropped words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_word) begin
            overflow <= 1'b1;
            if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Directed bench for hamming_rx_deserializer: a 12-bit instance for the
// framing, gap, restart, overflow and reset cases and a 15-bit instance
// for the full-FIFO simultaneous push/pop case.
module tb_hamming_rx_deserializer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 12-bit codeword instance (IP_BIT = 8)
    logic        in_valid = 1'b0;
    logic        in_start = 1'b0;
    logic        in_bit   = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [11:0] out_code;
    logic        overflow;
    logic [7:0]  drop_cnt;

    // 15-bit codeword instance (IP_BIT = 11)
    logic        v11 = 1'b0;
    logic        s11 = 1'b0;
    logic        b11 = 1'b0;
    logic        r11 = 1'b0;
    logic        ov11_valid;
    logic [14:0] code11;
    logic        of11;
    logic [7:0]  dc11;

    hamming_rx_deserializer #(.IP_BIT(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    hamming_rx_deserializer #(.IP_BIT(11), .DEPTH(2), .CNT_W(8)) dut11 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v11),
        .in_start  (s11),
        .in_bit    (b11),
        .out_valid (ov11_valid),
        .out_ready (r11),
        .out_code  (code11),
        .overflow  (of11),
        .drop_cnt  (dc11)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic start, input logic b);
        in_valid = 1'b1;
        in_start = start;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_start = 1'($urandom_range(0, 1));
        in_bit   = 1'($urandom_range(0, 1));
    endtask

    // gap_mask[i] set: idle gap_len cycles after bit i+1.
    task automatic send_word(input logic [11:0] w, input logic [11:0] gap_mask, input int gap_len);
        for (int i = 0; i < 12; i++) begin
            send_bit(i == 0, w[11-i]);
            if (gap_mask[i] && i < 11) begin
                idle(gap_len);
            end
        end
    endtask

    task automatic send_word11(input logic [14:0] w, input logic ready_on_last);
        for (int i = 0; i < 15; i++) begin
            v11 = 1'b1;
            s11 = (i == 0);
            b11 = w[14-i];
            if (i == 14) begin
                r11 = ready_on_last;
            end
            @(posedge clk);
            #1;
            v11 = 1'b0;
            s11 = 1'b0;
            r11 = 1'b0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] word;
        logic [11:0] gap_mask;
        int          gap_len;
        logic [11:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vecs[0] = '{word: 12'hA5C, gap_mask: 12'h000, gap_len: 0, exp_code: 12'hA5C};
        vecs[1] = '{word: 12'h3F0, gap_mask: 12'h108, gap_len: 3, exp_code: 12'h3F0};
        vecs[2] = '{word: 12'h000, gap_mask: 12'h000, gap_len: 0, exp_code: 12'h000};
        vecs[3] = '{word: 12'hFFF, gap_mask: 12'h7FF, gap_len: 1, exp_code: 12'hFFF};
        vecs[4] = '{word: 12'h801, gap_mask: 12'h001, gap_len: 5, exp_code: 12'h801};
        vecs[5] = '{word: 12'h5A3, gap_mask: 12'h0A4, gap_len: 2, exp_code: 12'h5A3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_code", 32'(out_code), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_out_valid11", 32'(ov11_valid), 32'h0);
        rst = 1'b0;
        idle(1);

        // Table: each word appears the cycle after its last bit, for one cycle.
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].word, vecs[v].gap_mask, vecs[v].gap_len);
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'h1);
            check($sformatf("vec%0d_code", v), 32'(out_code), 32'(vecs[v].exp_code));
            idle(1);
            check($sformatf("vec%0d_valid_drop", v), 32'(out_valid), 32'h0);
        end

        // Restart mid-word: only the fresh word emerges.
        for (int i = 0; i < 7; i++) begin
            send_bit(i == 0, 1'b1);
        end
        check("restart_no_partial", 32'(out_valid), 32'h0);
        send_word(12'h001, 12'h000, 0);
        check("restart_valid", 32'(out_valid), 32'h1);
        check("restart_code", 32'(out_code), 32'h001);
        check("restart_overflow", 32'(overflow), 32'h0);
        idle(1);
        check("restart_single", 32'(out_valid), 32'h0);

        // Overflow with DEPTH=2 and a stalled consumer.
        out_ready = 1'b0;
        send_word(12'h111, 12'h000, 0);
        exp_q.push_back(12'h111);
        send_word(12'h222, 12'h000, 0);
        exp_q.push_back(12'h222);
        check("ovf_head_stable", 32'(out_code), 32'h111);
        check("ovf_not_yet", 32'(overflow), 32'h0);
        send_word(12'h333, 12'h000, 0);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'h1);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            check("ovf_pop_valid", 32'(out_valid), 32'h1);
            check("ovf_pop_code", 32'(out_code), 32'(exp_q.pop_front()));
            idle(1);
        end
        check("ovf_drained", 32'(out_valid), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO, pop on the same edge as the last bit of a new word.
        send_word11(15'h1234, 1'b0);
        send_word11(15'h2345, 1'b0);
        check("w11_full_head", 32'(code11), 32'h1234);
        send_word11(15'h7ABC, 1'b1);
        check("w11_no_overflow", 32'(of11), 32'h0);
        check("w11_no_drop", 32'(dc11), 32'h0);
        check("w11_head2", 32'(code11), 32'h2345);
        check("w11_valid2", 32'(ov11_valid), 32'h1);
        r11 = 1'b1;
        idle(1);
        check("w11_head3", 32'(code11), 32'h7ABC);
        check("w11_valid3", 32'(ov11_valid), 32'h1);
        idle(1);
        check("w11_drained", 32'(ov11_valid), 32'h0);
        r11 = 1'b0;

        // Reset mid-word with one word queued.
        out_ready = 1'b0;
        send_word(12'h456, 12'h000, 0);
        for (int i = 0; i < 5; i++) begin
            send_bit(i == 0, 1'b1);
        end
        check("prerst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_overflow", 32'(overflow), 32'h0);
        check("midrst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("midrst_code", 32'(out_code), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Bits without in_start after reset must be ignored.
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0, 1'b1);
        end
        check("postrst_idle", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        send_word(12'h0F0, 12'h000, 0);
        check("postrst_valid", 32'(out_valid), 32'h1);
        check("postrst_code", 32'(out_code), 32'h0F0);
        idle(1);

        // Drop counter saturation: 300 words into a stalled 2-deep FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send_word(12'h100 + 12'(i), 12'h000, 0);
            if (i == 255) begin
                check("sat_254", 32'(drop_cnt), 32'd254);
            end
        end
        check("sat_cnt", 32'(drop_cnt), 32'd255);
        check("sat_overflow", 32'(overflow), 32'h1);
        check("sat_head", 32'(out_code), 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
